// File: rtl/char_stream_fifo.sv
// char_stream_fifo: character input buffer in front of the pattern-recognition FSM.
// It is a first-word-fall-through queue with a registered head.
// It can optionally case-fold ASCII letters and discard non-printable bytes.
module char_stream_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int CASE_FOLD = 0,
  parameter int FILTER_NP = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  // Folding and filtering only make sense for byte-wide characters.
  localparam bit IS_BYTE   = (DATA_W == 8);
  localparam bit DO_FOLD   = (CASE_FOLD != 0) && IS_BYTE;
  localparam bit DO_FILTER = (FILTER_NP != 0) && IS_BYTE;

  localparam logic [DATA_W-1:0] LOWER_A  = DATA_W'(8'h61);
  localparam logic [DATA_W-1:0] LOWER_Z  = DATA_W'(8'h7A);
  localparam logic [DATA_W-1:0] CASE_OFS = DATA_W'(8'h20);
  localparam logic [DATA_W-1:0] PRINT_LO = DATA_W'(8'h20);
  localparam logic [DATA_W-1:0] PRINT_HI = DATA_W'(8'h7E);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_next;
  logic [CW-1:0]     count_next;
  logic [DATA_W-1:0] folded;
  logic [DATA_W-1:0] head_next;
  logic              filtered;
  logic              push;
  logic              drop;
  logic              pop;

  // in_ready depends only on the registered count, so it can never loop back through out_ready.
  assign in_ready = (count != CW'(DEPTH));

  // The handshake decode and the next head value that gets loaded into the out_data register.
  always_comb begin
    filtered = DO_FILTER && ((in_data < PRINT_LO) || (in_data > PRINT_HI));
    folded   = in_data;
    if (DO_FOLD && (in_data >= LOWER_A) && (in_data <= LOWER_Z)) begin
      folded = in_data - CASE_OFS;
    end
    push       = in_valid && in_ready && !filtered;
    drop       = in_valid && in_ready && filtered;
    pop        = out_valid && out_ready;
    rd_next    = pop ? rd_ptr + PW'(1) : rd_ptr;
    count_next = count + CW'(push) - CW'(pop);
    // If the new head slot is the one being written this cycle, take the incoming byte directly.
    head_next  = (push && (rd_next == wr_ptr)) ? folded : mem[rd_next];
  end

  // The storage array has no reset because only slots covered by count are ever read.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= folded;
    end
  end

  // Pointers, count, the registered head, and the status flags. Flush takes priority over any traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr    <= rd_next;
      count     <= count_next;
      out_valid <= (count_next != '0);
      if (count_next != '0) begin
        out_data <= head_next;
      end
      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule
